// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply, multiply-accumulate and restoring divide
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] hi_in_i,
    input  logic [WIDTH-1:0] lo_in_i,
    input  logic             cancel_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o,
    output logic             div_by_zero_o
);
    localparam int W  = WIDTH;
    localparam int CW = $clog2((W > MUL_STAGES ? W : MUL_STAGES) + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

    state_e          state_q;
    logic [W-1:0]    a_q, b_q, dvs_q, rem_q, quo_q, res_hi_q, res_lo_q;
    logic [2*W-1:0]  acc_q;
    logic [2:0]      op_q;
    logic [CW-1:0]   cnt_q;
    logic            res_valid_q, dbz_q;

    logic            idle;
    logic [W-1:0]    m_a, m_b, abs_a, abs_b;
    logic [2:0]      m_op;
    logic            m_sgn;
    logic [2*W-1:0]  m_acc, m_ea, m_eb, prod, mul_res;
    logic [W-1:0]    s_rem, s_quo, s_dvs, n_rem, n_quo;
    logic [W:0]      sh, diff;
    logic            ge, d_sgn, neg_q, neg_r;
    logic [W-1:0]    fix_quo, fix_rem;

    assign idle = state_q == IDLE;

    // Multiply operands come straight from the ports on the accept edge (single-stage case)
    // and from the captured registers afterwards.
    assign m_a     = idle ? a_i : a_q;
    assign m_b     = idle ? b_i : b_q;
    assign m_op    = idle ? op_i : op_q;
    assign m_acc   = idle ? {hi_in_i, lo_in_i} : acc_q;
    assign m_sgn   = ~m_op[0];
    assign m_ea    = {{W{m_sgn & m_a[W-1]}}, m_a};
    assign m_eb    = {{W{m_sgn & m_b[W-1]}}, m_b};
    assign prod    = m_ea * m_eb;
    assign mul_res = m_op[2] ? (m_op[1] ? m_acc - prod : m_acc + prod) : prod;

    // The first quotient bit is produced on the accept edge from the port magnitudes,
    // so WIDTH iterations plus the sign fixup fit in WIDTH+1 clocks.
    assign abs_a   = (~op_i[0] & a_i[W-1]) ? -a_i : a_i;
    assign abs_b   = (~op_i[0] & b_i[W-1]) ? -b_i : b_i;
    assign s_rem   = idle ? '0 : rem_q;
    assign s_quo   = idle ? abs_a : quo_q;
    assign s_dvs   = idle ? abs_b : dvs_q;
    assign sh      = {s_rem, s_quo[W-1]};
    assign diff    = sh - {1'b0, s_dvs};
    assign ge      = sh >= {1'b0, s_dvs};
    assign n_rem   = ge ? diff[W-1:0] : sh[W-1:0];
    assign n_quo   = {s_quo[W-2:0], ge};

    assign d_sgn   = ~op_q[0];
    assign neg_q   = d_sgn & (a_q[W-1] ^ b_q[W-1]);
    assign neg_r   = d_sgn & a_q[W-1];
    assign fix_quo = neg_q ? -quo_q : quo_q;
    assign fix_rem = neg_r ? -rem_q : rem_q;

    assign op_ready_o    = idle;
    assign res_valid_o   = res_valid_q;
    assign res_hi_o      = res_hi_q;
    assign res_lo_o      = res_lo_q;
    assign div_by_zero_o = dbz_q;

    // Control FSM with operand capture, iteration and registered result outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            acc_q       <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            res_hi_q    <= '0;
            res_lo_q    <= '0;
            res_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
        end else if (cancel_i) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (op_valid_i) begin
                    a_q   <= a_i;
                    b_q   <= b_i;
                    op_q  <= op_i;
                    acc_q <= {hi_in_i, lo_in_i};
                    cnt_q <= '0;
                    if (!op_i[2] && op_i[1]) begin
                        if (b_i == '0) begin
                            res_hi_q    <= a_i;
                            res_lo_q    <= '1;
                            dbz_q       <= 1'b1;
                            res_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            dvs_q   <= abs_b;
                            rem_q   <= n_rem;
                            quo_q   <= n_quo;
                            cnt_q   <= CW'(1);
                            state_q <= DIV;
                        end
                    end else if (MUL_STAGES == 1) begin
                        {res_hi_q, res_lo_q} <= mul_res;
                        dbz_q       <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        state_q <= MUL;
                    end
                end
                MUL: if (cnt_q == CW'(MUL_STAGES - 2)) begin
                    {res_hi_q, res_lo_q} <= mul_res;
                    dbz_q       <= 1'b0;
                    res_valid_q <= 1'b1;
                    state_q     <= DONE;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                DIV: if (cnt_q == CW'(W)) begin
                    res_hi_q    <= fix_rem;
                    res_lo_q    <= fix_quo;
                    dbz_q       <= 1'b0;
                    res_valid_q <= 1'b1;
                    state_q     <= DONE;
                end else begin
                    rem_q <= n_rem;
                    quo_q <= n_quo;
                    cnt_q <= cnt_q + CW'(1);
                end
                DONE: if (res_ready_i) begin
                    res_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit at WIDTH=32, MUL_STAGES=2
module tb_muldiv_unit;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        op_valid_i = 1'b0;
    logic        op_ready_o;
    logic [2:0]  op_i = '0;
    logic [31:0] a_i = '0, b_i = '0, hi_in_i = '0, lo_in_i = '0;
    logic        cancel_i = 1'b0;
    logic        res_valid_o;
    logic        res_ready_i = 1'b0;
    logic [31:0] res_hi_o, res_lo_o;
    logic        div_by_zero_o;
    int          n_cmp = 0;
    int          n_err = 0;

    muldiv_unit #(.WIDTH(32), .MUL_STAGES(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
        .op_i(op_i), .a_i(a_i), .b_i(b_i), .hi_in_i(hi_in_i), .lo_in_i(lo_in_i),
        .cancel_i(cancel_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_hi_o(res_hi_o), .res_lo_o(res_lo_o), .div_by_zero_o(div_by_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo);
        op_i = op; a_i = a; b_i = b; hi_in_i = hi; lo_in_i = lo; op_valid_i = 1'b1;
        tick();
        op_valid_i = 1'b0;
        hi_in_i = 32'hDEAD_BEEF;
        lo_in_i = 32'h1234_5678;
        a_i = 32'h5A5A_5A5A;
        b_i = 32'hA5A5_A5A5;
    endtask

    task automatic wait_res(input string tag, input int lat_exp);
        int lat = 1;
        while (!res_valid_o && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(lat_exp));
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                       input int lat, input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
        accept(op, a, b, hi, lo);
        wait_res(tag, lat);
        chk({tag, " hi"}, 64'(res_hi_o), 64'(ehi));
        chk({tag, " lo"}, 64'(res_lo_o), 64'(elo));
        chk({tag, " dbz"}, 64'(div_by_zero_o), 64'(edbz));
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        chk({tag, " ready after handshake"}, 64'(op_ready_o), 64'd1);
        chk({tag, " valid after handshake"}, 64'(res_valid_o), 64'd0);
    endtask

    initial begin
        int seen;
        repeat (3) tick();
        chk("reset valid", 64'(res_valid_o), 64'd0);
        chk("reset hi", 64'(res_hi_o), 64'd0);
        chk("reset lo", 64'(res_lo_o), 64'd0);
        chk("reset dbz", 64'(div_by_zero_o), 64'd0);
        rst_ni = 1'b1;
        tick();
        chk("ready after reset", 64'(op_ready_o), 64'd1);

        run("MULT",  3'b000, 32'hFFFF_FFFE, 32'd3, 0, 0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        run("MULTU", 3'b001, 32'hFFFF_FFFE, 32'd3, 0, 0, 2, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
        run("DIV -7/2", 3'b010, 32'hFFFF_FFF9, 32'd2, 0, 0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run("DIVU big", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 33, 32'h8000_0000, 32'h0, 1'b0);
        run("DIV min/-1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 33, 32'h0, 32'h8000_0000, 1'b0);
        run("DIV 100/-7", 3'b010, 32'd100, 32'hFFFF_FFF9, 0, 0, 33, 32'd2, 32'hFFFF_FFF2, 1'b0);
        run("DIVU by 0", 3'b011, 32'd7, 32'd0, 0, 0, 1, 32'd7, 32'hFFFF_FFFF, 1'b1);
        run("DIVU 7/2", 3'b011, 32'd7, 32'd2, 0, 0, 33, 32'd1, 32'd3, 1'b0);
        run("MADDU", 3'b101, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 2, 32'd1, 32'd0, 1'b0);
        run("MSUB", 3'b110, 32'd1, 32'd1, 32'd0, 32'd0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run("MADD", 3'b100, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd10, 2, 32'd0, 32'd5, 1'b0);
        run("MSUBU", 3'b111, 32'h0001_0000, 32'h0001_0000, 32'd2, 32'd0, 2, 32'd1, 32'd0, 1'b0);

        accept(3'b001, 32'd6, 32'd7, 0, 0);
        wait_res("backpressure", 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp valid", 64'(res_valid_o), 64'd1);
            chk("bp ready", 64'(op_ready_o), 64'd0);
            chk("bp result", {res_hi_o, res_lo_o}, 64'd42);
        end
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        chk("bp ready after handshake", 64'(op_ready_o), 64'd1);

        accept(3'b010, 32'd1000, 32'd3, 0, 0);
        repeat (9) tick();
        cancel_i = 1'b1;
        tick();
        cancel_i = 1'b0;
        chk("cancel ready", 64'(op_ready_o), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (res_valid_o) seen++;
            tick();
        end
        chk("cancel no result", 64'(seen), 64'd0);
        run("MULTU after cancel", 3'b001, 32'd3, 32'd4, 0, 0, 2, 32'd0, 32'd12, 1'b0);

        accept(3'b010, 32'd1000, 32'd3, 0, 0);
        repeat (5) tick();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async rst valid", 64'(res_valid_o), 64'd0);
        chk("async rst ready", 64'(op_ready_o), 64'd1);
        chk("async rst result", {res_hi_o, res_lo_o}, 64'd0);
        chk("async rst dbz", 64'(div_by_zero_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        run("DIVU after reset", 3'b011, 32'd1000, 32'd3, 0, 0, 33, 32'd1, 32'd333, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide engine for the EX stage, generalising the fixed 32-bit mult/div pair behind the ALU. It accepts one operation per valid/ready handshake and runs signed or unsigned multiply, multiply-accumulate/subtract (MADD/MSUB family) or radix-2 restoring divide. It holds a `{hi,lo}` result until the consumer takes it. A `cancel` input lets the pipeline drop an in-flight operation on exception or flush.

## Interface
- `WIDTH`, 32: operand width; results are 2×WIDTH split into hi/lo.
- `MUL_STAGES`, 2: multiply latency in clocks, ≥1.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `op_valid`  in  1  operation request.
- `op_ready`  out  1  unit idle; `op_valid && op_ready` = accept.
- `op`  in  3  operation select:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU
  - 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU
- `a`, `b`  in  WIDTH  operands; for divide, `a` is the dividend and `b` the divisor.
- `hi_in`, `lo_in`  in  WIDTH  accumulator source for MADD/MSUB.
- `cancel`  in  1  abort the current operation; no result is produced.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes the result.
- `res_hi`, `res_lo`  out  WIDTH  result: product high/low, or remainder/quotient.
- `div_by_zero`  out  1  qualifies `res_*`; set for DIV/DIVU with `b==0`.

## Operation
- States: IDLE, MUL, DIV, DONE. `op_ready = (state==IDLE)`.
- **Accept** (IDLE, `op_valid`, `!cancel`): register `a`, `b`, `op`, `hi_in`, `lo_in`.
  - op 0/1/4–7 → MUL.
  - op 2/3 with `b!=0` → DIV.
  - op 2/3 with `b==0` → DONE directly.
- **MUL**:
  - Product is computed as 2×WIDTH; signed for MULT/MADD/MSUB, unsigned otherwise.
  - MADD*: `{hi_in,lo_in} + product`. MSUB*: `{hi_in,lo_in} − product`. Both are modulo 2^(2×WIDTH).
  - Count MUL_STAGES clocks, then go to DONE.
- **DIV**:
  - Signed ops: take magnitudes.
  - Run WIDTH iterations, one quotient bit per clock (shift, trial subtract, restore).
  - One fixup clock: quotient negated if `a[MSB]^b[MSB]`; remainder takes the dividend's sign.
  - Then go to DONE.
  - MIN/−1 gives quotient = MIN, remainder = 0; no flag.
- **Divide by zero**: `res_hi=a`, `res_lo=all-ones`, `div_by_zero=1`.
- **DONE**:
  - `res_valid=1`. `res_hi`, `res_lo` and `div_by_zero` stay stable until `res_ready`.
  - On `res_valid && res_ready` → IDLE.
- **cancel**: from any state → IDLE on the next edge. `res_valid` drops and results are discarded. In IDLE, cancel blocks acceptance that cycle. Cancel in DONE concurrent with `res_ready` still counts as cancel; the consumer must ignore that cycle.
- **Reset** (async, any state, including mid-divide): state IDLE, `res_valid=0`, `res_hi=res_lo=0`, `div_by_zero=0`, iteration counter 0. `op_ready=1` from the first edge after release.

## Timing
- All latencies are counted from the accept edge to the first cycle with `res_valid=1`:
  - MUL family: MUL_STAGES clocks.
  - DIV/DIVU: WIDTH+1 clocks.
  - Divide by zero: 1 clock.
- `op_ready` falls the cycle after accept and rises the cycle after the result handshake. There is no same-cycle re-accept, so a back-to-back op has a 1-cycle bubble.
- Outputs are registered; `op_ready` is decoded from state only, with no combinational path from `op_valid`.
- `hi_in`/`lo_in` are sampled only at accept; later changes have no effect.
- `res_ready` high while `res_valid` is low is ignored.

## Test plan
All scenarios use WIDTH=32, MUL_STAGES=2.
- MULT a=0xFFFFFFFE, b=3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA, `res_valid` 2 clocks after accept. MULTU on the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- Divide cases:
  - DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF, 33 clocks.
  - DIVU a=0x80000000, b=0xFFFFFFFF → lo=0, hi=0x80000000.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=7, b=0 → `div_by_zero=1`, hi=7, lo=0xFFFFFFFF, 1 clock. The next DIVU 7/2 → `div_by_zero=0`, lo=3, hi=1.
- Accumulate:
  - MADDU hi_in=0, lo_in=0xFFFFFFFF, a=b=1 → hi=1, lo=0.
  - MSUB hi_in=lo_in=0, a=b=1 → hi=lo=0xFFFFFFFF.
  - Change `hi_in` after accept → result unchanged.
- Backpressure: hold `res_ready=0` for 5 cycles in DONE → outputs stable, `op_ready=0`. Then handshake → `op_ready=1` on the next cycle.
- Abort:
  - Pulse `cancel` at DIV iteration 10 → `res_valid` never rises and `op_ready=1` on the next cycle. A following MULTU 3×4 → lo=12, hi=0.
  - Assert `rst` low mid-DIV → all outputs take reset values immediately.
